// File: rtl/tick_sched.sv
// tick_sched -- base-rate tick generator with four independently
// programmable tick channels.
//
// A prescaler divides iClk by PRE = CLOCKFREQ/BASEFREQ. The cycle where it
// sits at PRE-1 is the "base edge".
//
// Each channel divides the base rate by its period P. It emits a one-cycle
// tick (aligned with oBaseTick) and toggles a square wave on every
// terminal count.
//
// New configuration is written into a per-channel shadow register. The
// shadow is applied at a safe point, so that a running period is never cut
// short.
//
// Ports:
//   iClk        system clock (single domain)
//   iRst        synchronous active-high reset
//   iCfgValid   config write request
//   oCfgReady   shadow slot free for channel iCfgCh (combinational)
//   iCfgCh      target channel 0..3
//   iCfgPeriod  period in base ticks (0 behaves as disabled)
//   iCfgEn      channel enable
//   oBaseTick   one-cycle pulse, once per PRE cycles
//   oTick       per-channel one-cycle tick pulse
//   oSqw        per-channel square wave, toggled on each tick
//   oPending    per-channel shadow config not yet applied
module tick_sched #(
  parameter int CLOCKFREQ = 100_000_000,
  parameter int BASEFREQ  = 1000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCfgValid,
  output logic        oCfgReady,
  input  logic [1:0]  iCfgCh,
  input  logic [15:0] iCfgPeriod,
  input  logic        iCfgEn,
  output logic        oBaseTick,
  output logic [3:0]  oTick,
  output logic [3:0]  oSqw,
  output logic [3:0]  oPending
);

  localparam int PRE  = CLOCKFREQ / BASEFREQ;
  localparam int PREW = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [PREW-1:0] PRELAST = PREW'(PRE - 1);

  logic [PREW-1:0] preCnt;
  logic            baseEdge;

  assign baseEdge = (preCnt == PRELAST);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      preCnt    <= '0;
      oBaseTick <= 1'b0;
    end else begin
      oBaseTick <= baseEdge;
      preCnt    <= baseEdge ? '0 : preCnt + 1'b1;
    end
  end

  // Ready looks only at the registered pending bit. An accept therefore
  // can never coincide with the apply that clears it.
  assign oCfgReady = !oPending[iCfgCh];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gChan
      logic [15:0] periodReg;
      logic [15:0] cntReg;
      logic [15:0] shPeriodReg;
      logic        enReg;
      logic        shEnReg;
      logic        pendReg;
      logic        tickReg;
      logic        sqwReg;
      logic        effEn;
      logic        terminal;
      logic        accept;
      logic        newEff;

      assign effEn    = enReg && (periodReg != 16'd0);
      assign terminal = effEn && (cntReg == periodReg - 16'd1);
      assign accept   = iCfgValid && (iCfgCh == 2'(gi)) && !pendReg;
      assign newEff   = shEnReg && (shPeriodReg != 16'd0);

      always_ff @(posedge iClk) begin
        if (iRst) begin
          periodReg   <= '0;
          cntReg      <= '0;
          shPeriodReg <= '0;
          enReg       <= 1'b0;
          shEnReg     <= 1'b0;
          pendReg     <= 1'b0;
          tickReg     <= 1'b0;
          sqwReg      <= 1'b0;
        end else begin
          tickReg <= 1'b0;

          if (accept) begin
            shPeriodReg <= iCfgPeriod;
            shEnReg     <= iCfgEn;
            pendReg     <= 1'b1;
          end

          if (baseEdge) begin
            if (!effEn) begin
              cntReg <= '0;
              sqwReg <= 1'b0;
            end else if (terminal) begin
              cntReg  <= '0;
              tickReg <= 1'b1;
              sqwReg  <= ~sqwReg;
            end else begin
              cntReg <= cntReg + 16'd1;
            end

            // Apply the shadow only while idle or right at the end of a
            // period. This edge's tick (set above) is still emitted under
            // the old configuration.
            if (pendReg && (!effEn || terminal)) begin
              periodReg <= shPeriodReg;
              enReg     <= shEnReg;
              cntReg    <= '0;
              pendReg   <= 1'b0;
              if (!newEff) begin
                sqwReg <= 1'b0;
              end
            end
          end
        end
      end

      assign oTick[gi]    = tickReg;
      assign oSqw[gi]     = sqwReg;
      assign oPending[gi] = pendReg;
    end
  endgenerate

endmodule

// File: tb/tb_tick_sched.sv
module tb_tick_sched;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iCfgValid;
  logic        oCfgReady;
  logic [1:0]  iCfgCh;
  logic [15:0] iCfgPeriod;
  logic        iCfgEn;
  logic        oBaseTick;
  logic [3:0]  oTick;
  logic [3:0]  oSqw;
  logic [3:0]  oPending;

  int total = 0;
  int bad   = 0;

  tick_sched #(.CLOCKFREQ(100), .BASEFREQ(10)) dut (
    .iClk(iClk), .iRst(iRst), .iCfgValid(iCfgValid), .oCfgReady(oCfgReady),
    .iCfgCh(iCfgCh), .iCfgPeriod(iCfgPeriod), .iCfgEn(iCfgEn),
    .oBaseTick(oBaseTick), .oTick(oTick), .oSqw(oSqw), .oPending(oPending)
  );

  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge iClk);
  endtask

  // Advance to the next cycle showing oBaseTick (bounded).
  task automatic waitBase();
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (oBaseTick) break;
    end
  endtask

  // Count cycles until oTick[ch] is seen (bounded; 300 means timeout).
  task automatic waitTick(input int ch, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!oTick[ch] && n < 300);
  endtask

  task automatic cfgWrite(input logic [1:0] ch, input logic [15:0] p, input logic e);
    iCfgValid = 1'b1; iCfgCh = ch; iCfgPeriod = p; iCfgEn = e;
    step(1);
    iCfgValid = 1'b0;
  endtask

  task automatic test_reset();
    logic expB;
    iRst = 1'b1; iCfgValid = 1'b0; iCfgCh = 2'd0; iCfgPeriod = 16'd0; iCfgEn = 1'b0;
    step(3);
    total++;
    if (oBaseTick !== 1'b0 || oTick !== 4'h0 || oSqw !== 4'h0 || oPending !== 4'h0 || oCfgReady !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: base=%b tick=%b sqw=%b pend=%b ready=%b required 0 0000 0000 0000 1",
               oBaseTick, oTick, oSqw, oPending, oCfgReady);
    end
    iRst = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      step(1);
      expB = (i == 10 || i == 20);
      total++;
      if (oBaseTick !== expB) begin
        bad++;
        $display("FAIL base_tick_cycle%0d: got %b required %b", i, oBaseTick, expB);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_cfg();
    int n;
    waitBase();
    iCfgValid = 1'b1; iCfgCh = 2'd0; iCfgPeriod = 16'd3; iCfgEn = 1'b1;
    #1;
    total++;
    if (oCfgReady !== 1'b1) begin bad++; $display("FAIL cfg_ready_ch0: got %b required 1", oCfgReady); end
    step(1);
    iCfgValid = 1'b0;
    total++;
    if (oPending !== 4'b0001) begin bad++; $display("FAIL cfg_pending_set: got %b required 0001", oPending); end
    waitBase();
    total++;
    if (oBaseTick !== 1'b1 || oPending !== 4'b0000 || oTick !== 4'b0000) begin
      bad++; $display("FAIL cfg_apply: base=%b pend=%b tick=%b required 1 0000 0000", oBaseTick, oPending, oTick);
    end
    waitTick(0, n);
    total++;
    if (n != 30 || oSqw[0] !== 1'b1 || oBaseTick !== 1'b1) begin
      bad++; $display("FAIL cfg_first_tick: cycles=%0d sqw0=%b base=%b required 30 1 1", n, oSqw[0], oBaseTick);
    end
    waitTick(0, n);
    total++;
    if (n != 30 || oSqw[0] !== 1'b0) begin
      bad++; $display("FAIL cfg_second_tick: cycles=%0d sqw0=%b required 30 0", n, oSqw[0]);
    end
    $display("test_cfg done");
  endtask

  task automatic test_reconfig();
    int n;
    iCfgValid = 1'b1; iCfgCh = 2'd0; iCfgPeriod = 16'd5; iCfgEn = 1'b1;
    step(1);
    total++;
    if (oPending[0] !== 1'b1 || oCfgReady !== 1'b0) begin
      bad++; $display("FAIL reconf_stall_ch0: pend0=%b ready=%b required 1 0", oPending[0], oCfgReady);
    end
    iCfgValid = 1'b0; iCfgCh = 2'd1;
    #1;
    total++;
    if (oCfgReady !== 1'b1) begin bad++; $display("FAIL reconf_ready_ch1: got %b required 1", oCfgReady); end
    iCfgCh = 2'd0;
    step(10);
    total++;
    if (oPending[0] !== 1'b1) begin bad++; $display("FAIL reconf_still_pending: got %b required 1", oPending[0]); end
    waitTick(0, n);
    total++;
    if (n != 19 || oPending[0] !== 1'b0 || oSqw[0] !== 1'b1) begin
      bad++; $display("FAIL reconf_terminal: cycles=%0d pend0=%b sqw0=%b required 19 0 1", n, oPending[0], oSqw[0]);
    end
    waitTick(0, n);
    total++;
    if (n != 50 || oSqw[0] !== 1'b0) begin
      bad++; $display("FAIL reconf_period5: cycles=%0d sqw0=%b required 50 0", n, oSqw[0]);
    end
    $display("test_reconfig done");
  endtask

  task automatic test_ch2();
    cfgWrite(2'd2, 16'd0, 1'b1);
    total++;
    if (oPending[2] !== 1'b1) begin bad++; $display("FAIL ch2_pending: got %b required 1", oPending[2]); end
    waitBase();
    total++;
    if (oBaseTick !== 1'b1 || oPending[2] !== 1'b0 || oTick[2] !== 1'b0 || oSqw[2] !== 1'b0) begin
      bad++; $display("FAIL ch2_p0_apply: base=%b pend2=%b tick2=%b sqw2=%b required 1 0 0 0",
                      oBaseTick, oPending[2], oTick[2], oSqw[2]);
    end
    waitBase();
    total++;
    if (oBaseTick !== 1'b1 || oTick[2] !== 1'b0 || oSqw[2] !== 1'b0) begin
      bad++; $display("FAIL ch2_p0_idle: base=%b tick2=%b sqw2=%b required 1 0 0", oBaseTick, oTick[2], oSqw[2]);
    end
    cfgWrite(2'd2, 16'd1, 1'b1);
    waitBase();
    total++;
    if (oBaseTick !== 1'b1 || oPending[2] !== 1'b0 || oTick[2] !== 1'b0) begin
      bad++; $display("FAIL ch2_p1_apply: base=%b pend2=%b tick2=%b required 1 0 0", oBaseTick, oPending[2], oTick[2]);
    end
    waitBase();
    total++;
    if (oBaseTick !== 1'b1 || oTick[2] !== 1'b1 || oSqw[2] !== 1'b1) begin
      bad++; $display("FAIL ch2_p1_tick1: base=%b tick2=%b sqw2=%b required 1 1 1", oBaseTick, oTick[2], oSqw[2]);
    end
    waitBase();
    total++;
    if (oBaseTick !== 1'b1 || oTick[2] !== 1'b1 || oSqw[2] !== 1'b0) begin
      bad++; $display("FAIL ch2_p1_tick2: base=%b tick2=%b sqw2=%b required 1 1 0", oBaseTick, oTick[2], oSqw[2]);
    end
    $display("test_ch2 done");
  endtask

  task automatic test_disable();
    int n;
    cfgWrite(2'd1, 16'd2, 1'b1);
    waitTick(1, n);
    total++;
    if (n > 30 || oSqw[1] !== 1'b1) begin
      bad++; $display("FAIL dis_first_tick: cycles=%0d sqw1=%b required <=30 1", n, oSqw[1]);
    end
    cfgWrite(2'd1, 16'd2, 1'b0);
    waitTick(1, n);
    total++;
    if (n != 19 || oSqw[1] !== 1'b0 || oPending[1] !== 1'b0) begin
      bad++; $display("FAIL dis_terminal: cycles=%0d sqw1=%b pend1=%b required 19 0 0", n, oSqw[1], oPending[1]);
    end
    for (int i = 0; i < 60; i++) begin
      step(1);
      total++;
      if (oTick[1] !== 1'b0 || oSqw[1] !== 1'b0) begin
        bad++; $display("FAIL dis_hold_cycle%0d: tick1=%b sqw1=%b required 0 0", i, oTick[1], oSqw[1]);
      end
    end
    $display("test_disable done");
  endtask

  task automatic test_reset_mid();
    cfgWrite(2'd1, 16'd2, 1'b1);
    waitBase();
    cfgWrite(2'd3, 16'd4, 1'b1);
    step(3);
    total++;
    if (oPending !== 4'b1000) begin bad++; $display("FAIL mid_pending: got %b required 1000", oPending); end
    iRst = 1'b1;
    step(1);
    total++;
    if (oBaseTick !== 1'b0 || oTick !== 4'h0 || oSqw !== 4'h0 || oPending !== 4'h0 || oCfgReady !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_state: base=%b tick=%b sqw=%b pend=%b ready=%b required 0 0000 0000 0000 1",
               oBaseTick, oTick, oSqw, oPending, oCfgReady);
    end
    iRst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      total++;
      if (oTick !== 4'h0 || oSqw !== 4'h0 || oPending !== 4'h0) begin
        bad++; $display("FAIL mid_quiet_cycle%0d: tick=%b sqw=%b pend=%b required 0000 0000 0000", i, oTick, oSqw, oPending);
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_cfg();
    test_reconfig();
    test_ch2();
    test_disable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 SHALL have parameter CLOCKFREQ, default 100_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BASEFREQ, default 1000, meaning base tick rate in Hz; PRE = CLOCKFREQ/BASEFREQ, with PRE >= 2 required.
REQ-003 SHALL have port iClk  input  1  system clock; single clock domain.
REQ-004 SHALL have port iRst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port iCfgValid  input  1  config write request.
REQ-006 SHALL have port oCfgReady  output  1  config slot free for channel iCfgCh.
REQ-007 SHALL have port iCfgCh  input  2  target channel 0..3.
REQ-008 SHALL have port iCfgPeriod  input  16  period in base ticks.
REQ-009 SHALL have port iCfgEn  input  1  channel enable.
REQ-010 SHALL have port oBaseTick  output  1  one-cycle base tick pulse.
REQ-011 SHALL have port oTick  output  4  per-channel one-cycle tick pulse.
REQ-012 SHALL have port oSqw  output  4  per-channel square wave, toggled on each tick.
REQ-013 SHALL have port oPending  output  4  per-channel shadow config not yet applied.

Function
REQ-014 Prescaler SHALL count 0..PRE-1 and wrap to 0; the edge at PRE-1 is the "base edge".
REQ-015 oBaseTick SHALL be registered and high exactly one cycle after each base edge; period is PRE cycles.
REQ-016 Each channel SHALL hold active period P (16 bit), enable E, and counter C (16 bit).
REQ-017 A channel SHALL be effectively enabled only when E=1 and P!=0; period 0 with E=1 SHALL behave as disabled.
REQ-018 On a base edge, an effectively enabled channel with C==P-1 SHALL set C to 0, pulse oTick[n] high for one cycle coincident with oBaseTick, and toggle oSqw[n].
REQ-019 On any other base edge, an effectively enabled channel SHALL increment C; between base edges C SHALL hold.
REQ-020 P=1 SHALL produce oTick[n] on every base tick; P=65535 SHALL count without overflow.
REQ-021 A disabled channel SHALL hold C=0, oTick[n]=0 and oSqw[n]=0.
REQ-022 oCfgReady SHALL be combinational !oPending[iCfgCh].
REQ-023 A write SHALL be accepted when iCfgValid && oCfgReady: the shadow for iCfgCh captures iCfgPeriod and iCfgEn, and oPending[iCfgCh] is set the next cycle.
REQ-024 When a channel is pending, its shadow SHALL be applied on the next base edge if the channel is effectively disabled.
REQ-025 When a channel is pending and enabled, its shadow SHALL be applied on the base edge where the channel hits C==P-1, after that edge's tick is emitted.
REQ-026 On apply: P and E SHALL load from the shadow, C SHALL be set to 0, and oPending[n] SHALL clear.
REQ-027 On apply, if the new config is effectively disabled, oSqw[n] SHALL go to 0.
REQ-028 A write to a pending channel SHALL be stalled (ready low) and not dropped; the requester holds iCfgValid and payload.
REQ-029 In the cycle oPending clears, oCfgReady SHALL still reflect the registered pending bit, so an accept in the same cycle is impossible.
REQ-030 Writes to non-pending channels SHALL be accepted regardless of other channels' state; channels SHALL be fully independent.
REQ-031 All outputs except oCfgReady SHALL be registered.

Reset
REQ-032 While iRst=1 at a clock edge, the block SHALL clear prescaler, all P/E/C/shadows to 0, oBaseTick=0, oTick=0, oSqw=0 and oPending=0; oCfgReady=1.
REQ-033 Reset SHALL override any in-flight write or pending apply.
REQ-034 The first base tick after reset release SHALL occur PRE cycles later.

Verification (CLOCKFREQ=100, BASEFREQ=10, PRE=10)
REQ-035 Reset held then released -> all outputs 0, oCfgReady=1; oBaseTick first high 10 cycles after release, then every 10 cycles.
REQ-036 Write ch0 P=3 E=1 -> oPending[0] set, applied at next base edge, then oTick[0] every 30 cycles with oSqw[0] period 60 cycles.
REQ-037 Ch0 running P=3, write P=5 -> oCfgReady low for ch0 and high for ch1 until ch0's next terminal tick; subsequent ticks every 50 cycles.
REQ-038 Write ch2 P=0 E=1 -> after apply oTick[2]=0 and oSqw[2]=0; then write ch2 P=1 E=1 -> oTick[2] on every base tick.
REQ-039 Ch1 P=2 running with oSqw[1]=1, write E=0 -> at ch1 terminal edge the tick is emitted and oSqw toggles to 0, then holds 0 with no further ticks.
REQ-040 Assert iRst mid-period with ch0/ch1 active and ch3 pending -> next cycle all outputs 0, oPending=0, and no ticks until reconfigured.
